crc_32_checker: RTL and testbench
=================================

# crc_32_checker

Byte-serial CRC-32 receive checker. It is the far-end counterpart of the CRC-32 parallel generator. It accepts a frame of payload bytes followed by the 4 CRC bytes the generator appends, MSB byte first, and runs every byte through the same 8-bit-parallel CRC-32 update. It forwards only the payload bytes, removing the 4 trailing CRC bytes through a 4-byte delay window. At end of frame it reports pass/fail.

## Interface
- `CNT_W`, default 16: width of the received-byte counter and of `frame_len`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `load`  in  1  start-of-frame pulse; honoured only in IDLE.
- `d_valid`  in  1  `crc_in` carries a valid byte this cycle.
- `d_last`  in  1  qualifies the final byte of the frame (last CRC byte); meaningful only with `d_valid`.
- `crc_in`  in  8  received byte; bit 7 is first on the wire.
- `data_out`  out  8  payload byte with the CRC removed.
- `data_out_valid`  out  1  `data_out` is valid this cycle.
- `done`  out  1  one-cycle end-of-frame strobe.
- `crc_ok`  out  1  valid with `done`: residue is zero and the frame holds at least 5 bytes.
- `crc_err`  out  1  valid with `done`: the inverse of `crc_ok`.
- `frame_len`  out  CNT_W  valid with `done`: payload byte count, equal to received bytes minus 4; 0 if fewer than 4 bytes were received.

## Operation
- **CRC definition:** polynomial 0x04C11DB7, init 0x00000000, non-reflected, no final XOR. This is identical to the generator.
- **Update function:** identical to the generator's 32 XOR equations, with `crc_in[k]` aligned to `crc_reg[24+k]`.
- **Pass condition:** a correct frame, with the CRC appended MSB byte first, leaves a residue of 0x00000000.
- **IDLE:**
  - `crc_reg`, window fill count and byte counter are held at 0.
  - On `load`, go to RECV.
  - `d_valid` is ignored.
- **RECV:**
  - On each `d_valid`:
    - `crc_reg` takes the update of (`crc_reg`, `crc_in`).
    - The byte shifts into the 4-byte window.
    - The byte counter increments and saturates at all-ones.
  - When the window already holds 4 bytes before the shift, the oldest byte is driven on `data_out` with `data_out_valid` = 1 on the next cycle.
  - `d_valid` && `d_last` goes to CHECK. That byte is fully processed, and any byte it displaces from the window is emitted.
  - `load` in RECV is ignored.
  - Cycles without `d_valid` leave all state unchanged.
- **CHECK** (one cycle):
  - Register `done` = 1.
  - `crc_ok` = (`crc_reg` == 0) && (count ≥ 5).
  - `crc_err` = !`crc_ok`.
  - `frame_len` = count − 4, saturated at 0.
  - Go to IDLE.
  - Window bytes, which are the CRC bytes, are discarded, never output.
  - Input in CHECK is ignored.
- **Short frame:** fewer than 5 bytes gives `crc_err`, even when the residue is 0.
- **Reset mid-frame:** on `rst` low, immediately return to IDLE.
  - `crc_reg`, window, counter, `data_out` = 0x00.
  - `data_out_valid`, `done`, `crc_ok`, `crc_err` = 0.
  - `frame_len` = 0.
  - A partial frame is lost with no `done`.

## Timing
- All outputs are registered. Reset values are as listed under "Reset mid-frame".
- **Payload latency:** byte n (0-based) sampled at edge E_k appears on `data_out` during the cycle after the edge that samples byte n+4.
- **Result latency:** last byte sampled at edge E. State is CHECK after E. `done`/`crc_ok`/`crc_err`/`frame_len` are high/valid for exactly the one cycle following edge E+1.
- **Back-to-back frames:**
  - `load` may be asserted in the cycle `done` is visible; it is sampled in IDLE, so RECV begins one cycle later.
  - Minimum gap is 2 idle edges between the last byte and the next frame's first byte.
- `data_out_valid` and `done` are never high in the same cycle.

## Structure
- Package `crc32_pkg`:
  - `CRC32_POLY` = 32'h04C11DB7.
  - `CRC32_INIT` = 0.
  - State enum {IDLE, RECV, CHECK}.
  - Function `crc32_byte_update(crc, byte)`.
  - The generator is refactored to use the same function.
- Sub-module `crc_strip_window`: 4-deep byte shift register with a fill count. It emits the oldest byte on push when full and clears on frame start or reset.
- The top level holds the FSM, the counter and the result registers.

## Test plan
- **Reset:** hold `rst` low, then release → all outputs 0, state IDLE, `d_valid` without `load` produces no output.
- **Good frame:** `load`; bytes "123456789" (0x31..0x39) then 0x89,0xA1,0x89,0x7F with `d_last` on 0x7F → `data_out` 0x31..0x39 in order; `done` with `crc_ok`=1, `frame_len`=9.
- **Corrupted frame:** same frame with 0x35 replaced by 0x34 → `crc_err`=1, `crc_ok`=0, 9 bytes still forwarded.
- **Zero frame:** bytes 00 00 00 00 00 → `crc_ok`=1, `frame_len`=1, one output 0x00.
- **Short frame:** 00 00 00 00 (4 bytes) → `crc_err`=1, `frame_len`=0, no `data_out_valid`.
- **Gaps and reset:** random `d_valid` gaps on the good frame → identical result. `rst` asserted after byte 6 → outputs cleared, no `done`; next `load` plus good frame → `crc_ok`=1.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC-32 generator/checker pair.
//   CRC32_POLY / CRC32_INIT : polynomial and preset (non-reflected, no final XOR)
//   WIN_DEPTH               : number of trailing CRC bytes held back from the payload
//   state_e                 : checker FSM states
//   crc32_byte_update       : one byte through the CRC register, bit 7 of the byte first
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'h0000_0000;
  localparam int          WIN_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Unrolled serial LFSR. data[k] meets crc[24+k], so feeding bit 7 first
  // gives the same 32 XOR equations as the parallel generator.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = (c << 1) ^ CRC32_POLY;
      else                 c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_strip_window.sv
// 4-deep byte delay line that hides the trailing CRC bytes of a frame.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr_i           : synchronous clear (frame start / idle)
//   push_i, byte_i  : shift a received byte in
//   evict_o         : a push is displacing the oldest byte this cycle
//   evict_byte_o    : the byte being displaced (valid with evict_o)
module crc_strip_window
  import crc32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic [7:0] byte_i,
  output logic       evict_o,
  output logic [7:0] evict_byte_o
);

  localparam logic [2:0] FULL = 3'(WIN_DEPTH);

  // win_q[0] is the newest byte, win_q[WIN_DEPTH-1] the oldest.
  logic [7:0] win_q [WIN_DEPTH];
  logic [2:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= 8'h00;
      fill_q <= 3'd0;
    end else if (clr_i) begin
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= 8'h00;
      fill_q <= 3'd0;
    end else if (push_i) begin
      win_q[0] <= byte_i;
      for (int i = 1; i < WIN_DEPTH; i++) win_q[i] <= win_q[i-1];
      if (fill_q != FULL) fill_q <= fill_q + 3'd1;
    end
  end

  // Only bytes that are already four deep are payload; anything still in the
  // window when the frame ends is CRC and is dropped by the clear.
  assign evict_o      = push_i && !clr_i && (fill_q == FULL);
  assign evict_byte_o = win_q[WIN_DEPTH-1];

endmodule

// File: rtl/crc_32_checker.sv
// Byte-serial CRC-32 receive checker.
//   clk, rst        : clock, asynchronous active-low reset
//   load            : start of frame, taken in IDLE only
//   d_valid, d_last : byte strobe and final-byte marker
//   crc_in          : received byte (bit 7 first on the wire)
//   data_out(_valid): payload with the 4 trailing CRC bytes removed
//   done            : one-cycle end-of-frame strobe
//   crc_ok/crc_err  : result, valid with done
//   frame_len       : payload byte count, valid with done
//   dbg_state_o     : current FSM state
// Handshake: no backpressure. A byte is consumed on every clock edge where
// d_valid is high and the FSM is in RECV; data_out_valid is a one-cycle
// qualifier with no ready.
module crc_32_checker
  import crc32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             d_valid,
  input  logic             d_last,
  input  logic [7:0]       crc_in,
  output logic [7:0]       data_out,
  output logic             data_out_valid,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [CNT_W-1:0] frame_len,
  output state_e           dbg_state_o
);

  state_e           state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_d;
  logic             pass_d;
  logic [7:0]       dout_q;
  logic             dvalid_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;
  logic [CNT_W-1:0] len_q;

  logic             push;
  logic             evict;
  logic [7:0]       evict_byte;

  assign push  = (state_q == RECV) && d_valid;
  assign crc_d = crc32_byte_update(crc_q, crc_in);

  // A frame needs at least one payload byte besides the 4 CRC bytes, so a
  // zero residue on a short frame is still an error.
  assign pass_d = (crc_q == 32'h0) && (cnt_q >= CNT_W'(5));
  assign len_d  = (cnt_q >= CNT_W'(4)) ? (cnt_q - CNT_W'(4)) : '0;

  crc_strip_window u_window (
    .clk          (clk),
    .rst_n        (rst),
    .clr_i        (state_q == IDLE),
    .push_i       (push),
    .byte_i       (crc_in),
    .evict_o      (evict),
    .evict_byte_o (evict_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      crc_q    <= CRC32_INIT;
      cnt_q    <= '0;
      dout_q   <= 8'h00;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
    end else begin
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          crc_q <= CRC32_INIT;
          cnt_q <= '0;
          if (load) state_q <= RECV;
        end
        RECV: begin
          if (d_valid) begin
            crc_q <= crc_d;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (evict) begin
              dout_q   <= evict_byte;
              dvalid_q <= 1'b1;
            end
            if (d_last) state_q <= CHECK;
          end
        end
        CHECK: begin
          done_q  <= 1'b1;
          ok_q    <= pass_d;
          err_q   <= !pass_d;
          len_q   <= len_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dvalid_q;
  assign done           = done_q;
  assign crc_ok         = ok_q;
  assign crc_err        = err_q;
  assign frame_len      = len_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_crc_32_checker.sv
// Directed bench for crc_32_checker: known-good "123456789" frame, corrupted,
// zero, short, gapped, reset mid-frame and back-to-back frames.
module tb_crc_32_checker;
  import crc32_pkg::*;

  localparam int CNT_W = 16;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             d_valid = 1'b0;
  logic             d_last = 1'b0;
  logic [7:0]       crc_in = 8'h00;
  logic [7:0]       data_out;
  logic             data_out_valid;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [CNT_W-1:0] frame_len;
  state_e           dbg_state;

  always #5 clk = ~clk;

  crc_32_checker #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .d_valid        (d_valid),
    .d_last         (d_last),
    .crc_in         (crc_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .done           (done),
    .crc_ok         (crc_ok),
    .crc_err        (crc_err),
    .frame_len      (frame_len),
    .dbg_state_o    (dbg_state)
  );

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // scoreboard state
  logic [7:0]       exp_q [$];
  logic [7:0]       got_q [$];
  int               done_seen;
  int               done_cyc;
  int               first_out_cyc;
  int               overlap_cnt = 0;
  logic             last_ok;
  logic             last_err;
  logic [CNT_W-1:0] last_len;

  logic [7:0] frame_buf [0:15];
  int         frame_n;
  int         byte_cyc [0:15];

  // output monitor, samples away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (data_out_valid) begin
        if (got_q.size() == 0) first_out_cyc = cyc;
        got_q.push_back(data_out);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        last_ok  = crc_ok;
        last_err = crc_err;
        last_len = frame_len;
      end
      if (data_out_valid && done) overlap_cnt++;
    end
  end

  // driver tasks
  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_seen     = 0;
    first_out_cyc = -1;
  endtask

  task automatic set_good_frame(input bit corrupt);
    for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
    frame_buf[9]  = 8'h89;
    frame_buf[10] = 8'hA1;
    frame_buf[11] = 8'h89;
    frame_buf[12] = 8'h7F;
    if (corrupt) frame_buf[4] = 8'h34;
    frame_n = 13;
  endtask

  task automatic set_zero_frame(input int n);
    for (int i = 0; i < n; i++) frame_buf[i] = 8'h00;
    frame_n = n;
  endtask

  task automatic fill_expected();
    for (int i = 0; i < frame_n - 4; i++) exp_q.push_back(frame_buf[i]);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic send_frame(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      d_valid = 1'b1;
      crc_in  = frame_buf[i];
      d_last  = (i == frame_n - 1);
      @(posedge clk); #1;
      byte_cyc[i] = cyc;
      d_valid = 1'b0;
      d_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_seen >= target) break;
    end
    repeat (2) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h exp 00", data_out); end
    tests++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dov: got %b exp 0", data_out_valid); end
    tests++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    tests++; if (crc_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b exp 0", crc_ok); end
    tests++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", crc_err); end
    tests++; if (frame_len !== 16'd0) begin errors++; $display("FAIL reset_len: got %0d exp 0", frame_len); end
    tests++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b1;
    clear_mon();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      d_valid = 1'b1;
      crc_in  = 8'hA0 + 8'(i);
      d_last  = (i == 4);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (got_q.size() != 0) begin errors++; $display("FAIL idle_no_output: got %0d bytes exp 0", got_q.size()); end
    tests++; if (done_seen != 0) begin errors++; $display("FAIL idle_no_done: got %0d exp 0", done_seen); end
    tests++; if (dbg_state !== IDLE) begin errors++; $display("FAIL idle_state: got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_good_frame();
    clear_mon();
    set_good_frame(1'b0);
    fill_expected();
    pulse_load();
    send_frame(frame_n, 0);
    wait_done(1);
    tests++; if (got_q.size() != 9) begin errors++; $display("FAIL good_count: got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (done_seen != 1) begin errors++; $display("FAIL good_done_count: got %0d exp 1", done_seen); end
    tests++; if (last_ok !== 1'b1) begin errors++; $display("FAIL good_ok: got %b exp 1", last_ok); end
    tests++; if (last_err !== 1'b0) begin errors++; $display("FAIL good_err: got %b exp 0", last_err); end
    tests++; if (last_len !== 16'd9) begin errors++; $display("FAIL good_len: got %0d exp 9", last_len); end
    tests++; if (done_cyc != byte_cyc[12] + 1) begin errors++; $display("FAIL good_done_latency: got %0d exp %0d", done_cyc, byte_cyc[12] + 1); end
    tests++; if (first_out_cyc != byte_cyc[4]) begin errors++; $display("FAIL good_payload_latency: got %0d exp %0d", first_out_cyc, byte_cyc[4]); end
  endtask

  task automatic test_corrupt_frame();
    clear_mon();
    set_good_frame(1'b1);
    fill_expected();
    pulse_load();
    send_frame(frame_n, 0);
    wait_done(1);
    tests++; if (got_q.size() != 9) begin errors++; $display("FAIL bad_count: got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (done_seen != 1) begin errors++; $display("FAIL bad_done_count: got %0d exp 1", done_seen); end
    tests++; if (last_ok !== 1'b0) begin errors++; $display("FAIL bad_ok: got %b exp 0", last_ok); end
    tests++; if (last_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b exp 1", last_err); end
    tests++; if (last_len !== 16'd9) begin errors++; $display("FAIL bad_len: got %0d exp 9", last_len); end
  endtask

  task automatic test_zero_frame();
    clear_mon();
    set_zero_frame(5);
    pulse_load();
    send_frame(frame_n, 0);
    wait_done(1);
    tests++; if (got_q.size() != 1) begin errors++; $display("FAIL zero_count: got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL zero_byte: got %h exp 00", got_q[0]); end
    end
    tests++; if (last_ok !== 1'b1) begin errors++; $display("FAIL zero_ok: got %b exp 1", last_ok); end
    tests++; if (last_err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b exp 0", last_err); end
    tests++; if (last_len !== 16'd1) begin errors++; $display("FAIL zero_len: got %0d exp 1", last_len); end
  endtask

  task automatic test_short_frame();
    clear_mon();
    set_zero_frame(4);
    pulse_load();
    send_frame(frame_n, 0);
    wait_done(1);
    tests++; if (got_q.size() != 0) begin errors++; $display("FAIL short_count: got %0d exp 0", got_q.size()); end
    tests++; if (done_seen != 1) begin errors++; $display("FAIL short_done_count: got %0d exp 1", done_seen); end
    tests++; if (last_ok !== 1'b0) begin errors++; $display("FAIL short_ok: got %b exp 0", last_ok); end
    tests++; if (last_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b exp 1", last_err); end
    tests++; if (last_len !== 16'd0) begin errors++; $display("FAIL short_len: got %0d exp 0", last_len); end
  endtask

  task automatic test_gaps();
    clear_mon();
    set_good_frame(1'b0);
    fill_expected();
    pulse_load();
    send_frame(frame_n, 3);
    wait_done(1);
    tests++; if (got_q.size() != 9) begin errors++; $display("FAIL gap_count: got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (last_ok !== 1'b1) begin errors++; $display("FAIL gap_ok: got %b exp 1", last_ok); end
    tests++; if (last_len !== 16'd9) begin errors++; $display("FAIL gap_len: got %0d exp 9", last_len); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    set_good_frame(1'b0);
    pulse_load();
    send_frame(6, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data_out: got %h exp 00", data_out); end
    tests++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_dov: got %b exp 0", data_out_valid); end
    tests++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b exp 0", done); end
    tests++; if (frame_len !== 16'd0) begin errors++; $display("FAIL mid_len: got %0d exp 0", frame_len); end
    tests++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d exp 0", done_seen); end
    clear_mon();
    fill_expected();
    pulse_load();
    send_frame(frame_n, 0);
    wait_done(1);
    tests++; if (got_q.size() != 9) begin errors++; $display("FAIL after_rst_count: got %0d exp 9", got_q.size()); end
    tests++; if (last_ok !== 1'b1) begin errors++; $display("FAIL after_rst_ok: got %b exp 1", last_ok); end
    tests++; if (last_len !== 16'd9) begin errors++; $display("FAIL after_rst_len: got %0d exp 9", last_len); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    set_good_frame(1'b0);
    fill_expected();
    fill_expected();
    pulse_load();
    send_frame(frame_n, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    tests++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b exp 1", done); end
    // load while done is visible; first byte of the next frame right after
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    send_frame(frame_n, 0);
    wait_done(2);
    tests++; if (done_seen != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", done_seen); end
    tests++; if (last_ok !== 1'b1) begin errors++; $display("FAIL b2b_ok: got %b exp 1", last_ok); end
    tests++; if (last_len !== 16'd9) begin errors++; $display("FAIL b2b_len: got %0d exp 9", last_len); end
    tests++; if (got_q.size() != 18) begin errors++; $display("FAIL b2b_count: got %0d exp 18", got_q.size()); end
    for (int i = 0; i < 18 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (overlap_cnt != 0) begin errors++; $display("FAIL dov_done_overlap: got %0d exp 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_corrupt_frame();
    test_zero_frame();
    test_short_frame();
    test_gaps();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
